// File: rtl/nor_sweep_ctrl_pkg.sv
// Shared definitions for the NOR-network sweep sequencer.
// Contents:
//   state_t   - sequencer states IDLE/APPLY/SAMPLE/FINISH
//   NUM_VEC   - number of input vectors swept (all combinations of x,y,z)
//   GOLDEN_TT - correct truth table of the NOR network, nibble i = {O4,O3,O2,O1}
//               for {x,y,z} = i, with O1=O2=O3=(x|y)&~z and O4=(y|z)&~x
//   tt_slice  - extracts the expected nibble of one vector from a table
package nor_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int          NUM_VEC   = 8;
  localparam logic [31:0] GOLDEN_TT = 32'h0707_8F80;

  function automatic logic [3:0] tt_slice(input logic [31:0] tt, input logic [2:0] i);
    return tt[4*i +: 4];
  endfunction

endpackage

// File: rtl/nor_sweep_ctrl_settle_cnt.sv
// sweep_settle_cnt: settle-time counter for one applied vector.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clr      - force count back to zero (has priority over en)
//   en       - advance the count by one
//   tc       - terminal count: high while count == SETTLE_CYCLES-1
module sweep_settle_cnt #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/nor_sweep_ctrl.sv
// nor_sweep_ctrl: steps the 3-input NOR datapath through all 8 input vectors,
// holds each for SETTLE_CYCLES, samples the 4 outputs and compares them with a
// snapshot of the caller's truth table.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - request a sweep (accepted only in IDLE, not with abort)
//   abort        - cancel a sweep in progress
//   hold         - pause sequencing in APPLY/SAMPLE
//   expect_tt    - golden table, vector i at [4i+3:4i] = {O4,O3,O2,O1}
//   dut_o        - datapath outputs {O4,O3,O2,O1}
//   dut_xyz      - datapath inputs {x,y,z}, equals the vector index
//   busy, done   - sweep in progress / one-cycle completion pulse
//   pass         - last completed sweep had no mismatches
//   fail_mask    - bit i set when vector i mismatched
//   sample_valid - one-cycle strobe per sample
//   sample_idx   - vector index of the latest sample
//   sample_data  - dut_o captured at the latest sample
module nor_sweep_ctrl
  import nor_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        hold,
  input  logic [31:0] expect_tt,
  input  logic [3:0]  dut_o,
  output logic [2:0]  dut_xyz,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  fail_mask,
  output logic        sample_valid,
  output logic [2:0]  sample_idx,
  output logic [3:0]  sample_data
);

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [31:0] tt_snap;
  logic        cnt_tc;
  logic        cnt_clr;
  logic        accept;
  logic        sample_fire;
  logic        finish_ok;
  logic        mismatch;

  sweep_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_settle_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (~hold),
    .tc (cnt_tc)
  );

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    sample_fire = 1'b0;
    finish_ok   = 1'b0;
    // Counter only runs in APPLY; every entry into APPLY starts from zero.
    cnt_clr     = (state != APPLY) || abort;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!hold && cnt_tc) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!hold) begin
          sample_fire = 1'b1;
          state_nxt   = (idx == 3'(NUM_VEC - 1)) ? FINISH : APPLY;
        end
      end
      FINISH: begin
        finish_ok = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mismatch = (dut_o != tt_slice(tt_snap, idx));
  assign dut_xyz  = (state == APPLY || state == SAMPLE) ? idx : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_mask    <= '0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_data  <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt == APPLY) || (state_nxt == SAMPLE);
      done         <= finish_ok;
      sample_valid <= sample_fire;
      if (accept) begin
        idx       <= '0;
        fail_mask <= '0;
        pass      <= 1'b0;
      end
      if (sample_fire) begin
        sample_idx     <= idx;
        sample_data    <= dut_o;
        fail_mask[idx] <= mismatch;
        // idx stops at the last vector; FINISH is reached only from there.
        if (idx != 3'(NUM_VEC - 1)) begin
          idx <= idx + 3'd1;
        end
      end
      // fail_mask already holds the last vector's result by the FINISH cycle.
      if (finish_ok) begin
        pass <= ~|fail_mask;
      end
      if (abort && state != IDLE) begin
        pass <= 1'b0;
      end
    end
  end

  // Table snapshot is data only; it is always loaded before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      tt_snap <= expect_tt;
    end
  end

endmodule

// File: doc/nor_sweep_ctrl.md
Name: nor_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the 3-input/4-output NOR-network datapath (inputs x,y,z; outputs O1..O4).
- Drives all 8 input vectors in order and waits a programmable settle time per vector.
- Samples the four outputs and compares them against a caller-supplied 32-bit truth table.
- Reports per-vector mismatches and an overall pass flag through a start/busy/done handshake.
- Sits between the lab test harness (switches/LEDs or a testbench) and the combinational datapath instance.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.
CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a sweep; sampled only in IDLE.
abort  input  1  cancel a sweep in progress; synchronous.
hold  input  1  freeze sequencing (pause) while high.
expect_tt  input  32  golden table; vector i occupies bits [4i+3:4i] = {O4,O3,O2,O1}.
dut_o  input  4  datapath outputs {O4,O3,O2,O1}.
dut_xyz  output  3  datapath inputs {x,y,z}; x is MSB; equals vector index.
busy  output  1  high from the start-accept edge until done or abort.
done  output  1  one-cycle pulse when a sweep completes.
pass  output  1  high when the last completed sweep had zero mismatches.
fail_mask  output  8  bit i set when vector i mismatched.
sample_valid  output  1  one-cycle pulse on each sample.
sample_idx  output  3  vector index of the current sample.
sample_data  output  4  dut_o captured at that sample.

Behaviour:
Reset values:
- All outputs are 0; state = IDLE.
- rst overrides every other input, including mid-sweep; results are cleared.

State machine (one-hot or binary; encodings come from the shared include):
- IDLE: dut_xyz=0, busy=0. If start=1 and abort=0: snapshot expect_tt into an internal register, idx<=0, cnt<=0, fail_mask<=0, pass<=0, go to APPLY.
- APPLY: dut_xyz=idx, busy=1. cnt increments each cycle. After SETTLE_CYCLES cycles in APPLY, go to SAMPLE.
- SAMPLE (1 cycle):
  - sample_valid=1, sample_idx=idx, sample_data=dut_o.
  - fail_mask[idx] <= (dut_o != snapshot slice idx).
  - If idx==7 go to FINISH; else idx<=idx+1, cnt<=0, go to APPLY.
  - dut_xyz stays equal to idx during SAMPLE.
- FINISH (1 cycle): done=1, busy=0, pass <= ~|fail_mask_final, where fail_mask_final includes the vector-7 result. Go to IDLE.

Timing and latency:
- Each vector takes SETTLE_CYCLES+1 cycles.
- done is asserted exactly 8*(SETTLE_CYCLES+1)+1 cycles after the start-accept edge.

hold:
- In APPLY or SAMPLE, hold=1 freezes state, cnt and idx. No sample_valid is issued while held; a SAMPLE cycle with hold=1 is deferred.
- hold has no effect in IDLE or FINISH.

abort:
- In any non-IDLE state, the next state is IDLE with busy=0, pass=0, and no done pulse.
- fail_mask keeps the partial results.
- abort takes precedence over hold and over start.

Other rules:
- start while busy is ignored; no queuing.
- expect_tt changes mid-sweep have no effect because of the snapshot.
- idx never wraps: FINISH is reached only from idx==7.
- pass and fail_mask hold their values in IDLE until the next accepted start.
- Sample registers (sample_idx, sample_data) hold their last value; sample_valid is a single-cycle strobe.

Decomposition:
- Shared include file (nor_sweep_defs.vh):
  - state localparams IDLE/APPLY/SAMPLE/FINISH;
  - NUM_VEC=8;
  - GOLDEN_TT = 32'h0707_8F80, the correct table for the NOR network: O1=O2=O3=(x|y)&~z, O4=(y|z)&~x.
- One natural sub-module, sweep_settle_cnt: loadable counter with clear, enable (~hold) and terminal-count flag at SETTLE_CYCLES-1.

Test Plan:
1. rst=1 for 2 cycles, then release -> all outputs 0, dut_xyz=0, state IDLE.
2. SETTLE_CYCLES=2, expect_tt=32'h0707_8F80, correct datapath attached, start pulse -> dut_xyz steps 0..7 holding 3 cycles each; sample_data sequence 0,8,F,8,7,0,7,0; done 25 cycles after accept; pass=1, fail_mask=8'h00.
3. Same as 2 with expect_tt=32'h0707_8F8F (vector 0 wrong) -> pass=0, fail_mask=8'h01, done still at 25 cycles.
4. hold=1 for 5 cycles during vector 3 APPLY -> done at 30 cycles; sample count remains 8; results identical to scenario 2.
5. abort asserted during vector 4 -> busy=0 the next cycle, no done, pass=0, fail_mask bits 0..3 reflect the completed samples; a subsequent start runs a full sweep.
6. start held high through a sweep and start+abort together in IDLE -> no second sweep while busy; simultaneous start+abort is not accepted (busy stays 0).
